// File: rtl/ex_stage_pkg.sv
// Shared definitions for the amber execute stage: widths, opcodes, condition
// codes, flag bit positions, the registered MEM/WB payload and small decode helpers.
// Optional feature macro used by the stage: EX_ROTATE_EN (rotate opcodes).
package ex_stage_pkg;

  localparam int unsigned DATA_W  = 24;
  localparam int unsigned ADDR_W  = 48;
  localparam int unsigned IMM_W   = 12;
  localparam int unsigned OPC_W   = 8;
  localparam int unsigned CC_W    = 4;
  localparam int unsigned FLAG_W  = 4;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned NBANK   = 4;

  // SR index holding the flags
  localparam logic [1:0] SR_FL = 2'b10;

  // Flag bit positions inside F = {V,C,N,Z}
  localparam int unsigned FL_Z = 0;
  localparam int unsigned FL_N = 1;
  localparam int unsigned FL_C = 2;
  localparam int unsigned FL_V = 3;

  typedef enum logic [OPC_W-1:0] {
    OPC_NOP   = 8'h00, OPC_MOVUR = 8'h01, OPC_MOVUI = 8'h02,
    OPC_ADDUR = 8'h03, OPC_ADDUI = 8'h04, OPC_SUBUR = 8'h05,
    OPC_SUBUI = 8'h06, OPC_ANDUR = 8'h07, OPC_ANDUI = 8'h08,
    OPC_ORUR  = 8'h09, OPC_ORUI  = 8'h0A, OPC_XORUR = 8'h0B,
    OPC_XORUI = 8'h0C, OPC_NOTUR = 8'h0D, OPC_SHLUR = 8'h0E,
    OPC_SHLUI = 8'h0F, OPC_SHRUR = 8'h10, OPC_SHRUI = 8'h11,
    OPC_ROLUR = 8'h12, OPC_ROLUI = 8'h13, OPC_RORUR = 8'h14,
    OPC_RORUI = 8'h15, OPC_CMPUR = 8'h16, OPC_CMPUI = 8'h17,
    OPC_TSTUR = 8'h18, OPC_MCCUR = 8'h19, OPC_LUIUI = 8'h1A
  } opc_e;

  typedef enum logic [CC_W-1:0] {
    CC_AL = 4'h0, CC_EQ = 4'h1, CC_NE = 4'h2, CC_CS = 4'h3,
    CC_CC = 4'h4, CC_MI = 4'h5, CC_PL = 4'h6
  } cc_e;

  // Registered payload handed to MEM/WB
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [OPC_W-1:0]  opc;
    logic [3:0]        tgt_gp;
    logic              tgt_gp_we;
    logic [1:0]        tgt_sr;
    logic              tgt_sr_we;
    logic [1:0]        tgt_ar;
    logic              tgt_ar_we;
    logic [DATA_W-1:0] result;
    logic [ADDR_W-1:0] sr_result;
    logic [ADDR_W-1:0] ar_result;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] branch_pc;
    logic              branch_taken;
  } ex_out_t;

  // Immediate-class opcodes take {bank0, imm12} as second operand
  function automatic logic is_ui(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_MOVUI, OPC_ADDUI, OPC_SUBUI, OPC_ANDUI, OPC_ORUI, OPC_XORUI,
      OPC_SHLUI, OPC_SHRUI, OPC_ROLUI, OPC_RORUI, OPC_CMPUI, OPC_LUIUI:
        return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Condition evaluation for MCCur
  function automatic logic cc_true(input logic [CC_W-1:0] cc,
                                   input logic [FLAG_W-1:0] f);
    case (cc)
      CC_AL:   return 1'b1;
      CC_EQ:   return f[FL_Z];
      CC_NE:   return !f[FL_Z];
      CC_CS:   return f[FL_C];
      CC_CC:   return !f[FL_C];
      CC_MI:   return f[FL_N];
      CC_PL:   return !f[FL_N];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/RF -> EX -> MEM/WB bundle. iw_* are produced by decode/register-file,
// ow_* are the registered execute results. master = upstream driver, slave = ex_stage.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [ADDR_W-1:0] iw_pc;
  logic [DATA_W-1:0] iw_instr;
  logic [OPC_W-1:0]  iw_opc;
  logic              iw_sgn_en;
  logic              iw_imm_en;
  logic [13:0]       iw_imm14_val;
  logic [11:0]       iw_imm12_val;
  logic [9:0]        iw_imm10_val;
  logic [15:0]       iw_imm16_val;
  logic [CC_W-1:0]   iw_cc;
  logic [3:0]        iw_tgt_gp;
  logic              iw_tgt_gp_we;
  logic [1:0]        iw_tgt_sr;
  logic              iw_tgt_sr_we;
  logic [1:0]        iw_tgt_ar;
  logic [3:0]        iw_src_gp;
  logic [1:0]        iw_src_ar;
  logic [1:0]        iw_src_sr;
  logic [DATA_W-1:0] iw_src_gp_val;
  logic [DATA_W-1:0] iw_tgt_gp_val;
  logic [ADDR_W-1:0] iw_src_ar_val;
  logic [ADDR_W-1:0] iw_tgt_ar_val;
  logic [ADDR_W-1:0] iw_src_sr_val;
  logic [ADDR_W-1:0] iw_tgt_sr_val;
  logic              iw_flush;
  logic              iw_stall;

  logic [ADDR_W-1:0] ow_pc;
  logic [DATA_W-1:0] ow_instr;
  logic [OPC_W-1:0]  ow_opc;
  logic [3:0]        ow_tgt_gp;
  logic              ow_tgt_gp_we;
  logic [1:0]        ow_tgt_sr;
  logic              ow_tgt_sr_we;
  logic [1:0]        ow_tgt_ar;
  logic              ow_tgt_ar_we;
  logic [DATA_W-1:0] ow_result;
  logic [ADDR_W-1:0] ow_sr_result;
  logic [ADDR_W-1:0] ow_ar_result;
  logic [ADDR_W-1:0] ow_addr;
  logic [ADDR_W-1:0] ow_branch_pc;
  logic              ow_branch_taken;

  modport master (
    output iw_pc, iw_instr, iw_opc, iw_sgn_en, iw_imm_en, iw_imm14_val, iw_imm12_val,
           iw_imm10_val, iw_imm16_val, iw_cc, iw_tgt_gp, iw_tgt_gp_we, iw_tgt_sr,
           iw_tgt_sr_we, iw_tgt_ar, iw_src_gp, iw_src_ar, iw_src_sr, iw_src_gp_val,
           iw_tgt_gp_val, iw_src_ar_val, iw_tgt_ar_val, iw_src_sr_val, iw_tgt_sr_val,
           iw_flush, iw_stall,
    input  ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_gp_we, ow_tgt_sr, ow_tgt_sr_we,
           ow_tgt_ar, ow_tgt_ar_we, ow_result, ow_sr_result, ow_ar_result, ow_addr,
           ow_branch_pc, ow_branch_taken
  );

  modport slave (
    input  iw_pc, iw_instr, iw_opc, iw_sgn_en, iw_imm_en, iw_imm14_val, iw_imm12_val,
           iw_imm10_val, iw_imm16_val, iw_cc, iw_tgt_gp, iw_tgt_gp_we, iw_tgt_sr,
           iw_tgt_sr_we, iw_tgt_ar, iw_src_gp, iw_src_ar, iw_src_sr, iw_src_gp_val,
           iw_tgt_gp_val, iw_src_ar_val, iw_tgt_ar_val, iw_src_sr_val, iw_tgt_sr_val,
           iw_flush, iw_stall,
    output ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_gp_we, ow_tgt_sr, ow_tgt_sr_we,
           ow_tgt_ar, ow_tgt_ar_we, ow_result, ow_sr_result, ow_ar_result, ow_addr,
           ow_branch_pc, ow_branch_taken
  );
endinterface

// File: rtl/ex_stage_alu.sv
// Combinational unsigned ALU for the execute stage.
// Ports: opc (opcode), t (Rt), opnd (Rs or {bank0,imm12}), amt (shift amount)
//        -> r_c (24-bit result), f_c (flags {V,C,N,Z}).
// Rotates exist only when EX_ROTATE_EN is defined; otherwise they fall to R=0.
module ex_stage_alu
  import ex_stage_pkg::*;
(
  input  logic [OPC_W-1:0]   opc,
  input  logic [DATA_W-1:0]  t,
  input  logic [DATA_W-1:0]  opnd,
  input  logic [SHAMT_W-1:0] amt,
  output logic [DATA_W-1:0]  r_c,
  output logic [FLAG_W-1:0]  f_c
);

  logic [DATA_W:0] sum_c;
  logic [DATA_W:0] dif_c;
  logic            carry_c;
  logic            shift_big_c;

  // Extra top bit gives carry-out on add and borrow (T<operand) on subtract
  assign sum_c       = {1'b0, t} + {1'b0, opnd};
  assign dif_c       = {1'b0, t} - {1'b0, opnd};
  assign shift_big_c = (amt >= SHAMT_W'(DATA_W));

`ifdef EX_ROTATE_EN
  logic [SHAMT_W-1:0]  rot_c;
  logic [2*DATA_W-1:0] rol_c;
  logic [2*DATA_W-1:0] ror_c;
  // amt < 32, so one conditional subtract gives amt mod 24
  assign rot_c = shift_big_c ? amt - SHAMT_W'(DATA_W) : amt;
  assign rol_c = {t, t} << rot_c;
  assign ror_c = {t, t} >> rot_c;
`endif

  always_comb begin
    r_c     = '0;
    carry_c = 1'b0;
    case (opc)
      OPC_MOVUR, OPC_MOVUI: r_c = opnd;
      OPC_ADDUR, OPC_ADDUI: begin
        r_c     = sum_c[DATA_W-1:0];
        carry_c = sum_c[DATA_W];
      end
      OPC_SUBUR, OPC_SUBUI, OPC_CMPUR, OPC_CMPUI: begin
        r_c     = dif_c[DATA_W-1:0];
        carry_c = dif_c[DATA_W];
      end
      OPC_ANDUR, OPC_ANDUI: r_c = t & opnd;
      OPC_ORUR,  OPC_ORUI:  r_c = t | opnd;
      OPC_XORUR, OPC_XORUI: r_c = t ^ opnd;
      OPC_NOTUR:            r_c = ~t;
      OPC_TSTUR:            r_c = t;
      OPC_SHLUR, OPC_SHLUI: r_c = shift_big_c ? '0 : t << amt;
      OPC_SHRUR, OPC_SHRUI: r_c = shift_big_c ? '0 : t >> amt;
`ifdef EX_ROTATE_EN
      OPC_ROLUR, OPC_ROLUI: r_c = rol_c[2*DATA_W-1:DATA_W];
      OPC_RORUR, OPC_RORUI: r_c = ror_c[DATA_W-1:0];
`endif
      default:              r_c = '0;
    endcase
  end

  assign f_c = {1'b0, carry_c, r_c[DATA_W-1], (r_c == '0)};

endmodule

// File: rtl/ex_stage.sv
// Amber execute stage: operand select, MCC condition evaluation, LUI bank
// registers and the single-cycle output register toward MEM/WB.
// Ports: iw_clk (rising edge), iw_rst (async active-low),
//        b (ex_stage_if.slave: decoded operands in, registered results out).
// Config: EX_ROTATE_EN enables the ROL/ROR opcodes.
module ex_stage
  import ex_stage_pkg::*;
(
  input logic         iw_clk,
  input logic         iw_rst,
  ex_stage_if.slave   b
);

  logic [NBANK-1:0][IMM_W-1:0] bank_q;
  ex_out_t                     out_q;
  ex_out_t                     nxt_c;
  logic                        bank_we_c;
  logic [DATA_W-1:0]           opnd_c;
  logic [SHAMT_W-1:0]          amt_c;
  logic [FLAG_W-1:0]           fl_in_c;
  logic [DATA_W-1:0]           alu_r_c;
  logic [FLAG_W-1:0]           alu_f_c;
  logic                        unused_c;

  // Second operand and shift amount: register class uses Rs, immediate class uses bank0:imm12
  assign opnd_c  = is_ui(b.iw_opc) ? {bank_q[0], b.iw_imm12_val} : b.iw_src_gp_val;
  assign amt_c   = is_ui(b.iw_opc) ? b.iw_imm12_val[SHAMT_W-1:0]
                                   : b.iw_src_gp_val[SHAMT_W-1:0];
  // MCC reads flags only when the selected SR is the flag register
  assign fl_in_c = (b.iw_src_sr == SR_FL) ? b.iw_src_sr_val[FLAG_W-1:0] : '0;

  ex_stage_alu u_alu (
    .opc  (b.iw_opc),
    .t    (b.iw_tgt_gp_val),
    .opnd (opnd_c),
    .amt  (amt_c),
    .r_c  (alu_r_c),
    .f_c  (alu_f_c)
  );

  // Next payload; unknown opcodes leave result and every write enable at 0
  always_comb begin
    nxt_c        = '0;
    bank_we_c    = 1'b0;
    nxt_c.pc     = b.iw_pc;
    nxt_c.instr  = b.iw_instr;
    nxt_c.opc    = b.iw_opc;
    nxt_c.tgt_gp = b.iw_tgt_gp;
    nxt_c.tgt_sr = b.iw_tgt_sr;
    nxt_c.tgt_ar = b.iw_tgt_ar;
    case (b.iw_opc)
      OPC_MOVUR, OPC_MOVUI: begin
        nxt_c.result    = alu_r_c;
        nxt_c.tgt_gp_we = b.iw_tgt_gp_we;
        nxt_c.tgt_sr_we = b.iw_tgt_sr_we;
      end
      OPC_MCCUR: begin
        nxt_c.result    = cc_true(b.iw_cc, fl_in_c) ? b.iw_src_gp_val : b.iw_tgt_gp_val;
        nxt_c.tgt_gp_we = b.iw_tgt_gp_we;
        nxt_c.tgt_sr_we = b.iw_tgt_sr_we;
      end
      OPC_LUIUI: begin
        bank_we_c       = 1'b1;
        nxt_c.tgt_sr_we = b.iw_tgt_sr_we;
      end
      OPC_CMPUR, OPC_CMPUI, OPC_TSTUR: begin
        nxt_c.result    = alu_r_c;
        nxt_c.tgt_sr    = SR_FL;
        nxt_c.tgt_sr_we = 1'b1;
        nxt_c.sr_result = ADDR_W'(alu_f_c);
      end
      OPC_ADDUR, OPC_ADDUI, OPC_SUBUR, OPC_SUBUI, OPC_ANDUR, OPC_ANDUI,
      OPC_ORUR, OPC_ORUI, OPC_XORUR, OPC_XORUI, OPC_NOTUR,
      OPC_SHLUR, OPC_SHLUI, OPC_SHRUR, OPC_SHRUI
`ifdef EX_ROTATE_EN
      , OPC_ROLUR, OPC_ROLUI, OPC_RORUR, OPC_RORUI
`endif
      : begin
        nxt_c.result    = alu_r_c;
        nxt_c.tgt_gp_we = b.iw_tgt_gp_we;
        nxt_c.tgt_sr    = SR_FL;
        nxt_c.tgt_sr_we = 1'b1;
        nxt_c.sr_result = ADDR_W'(alu_f_c);
      end
      default: ;
    endcase
  end

  // Stall freezes everything; flush inserts an all-zero bubble without touching banks
  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      out_q  <= '0;
      bank_q <= '0;
    end else if (!b.iw_stall) begin
      if (b.iw_flush) begin
        out_q <= '0;
      end else begin
        out_q <= nxt_c;
        if (bank_we_c) bank_q[b.iw_instr[15:14]] <= b.iw_imm12_val;
      end
    end
  end

  assign b.ow_pc           = out_q.pc;
  assign b.ow_instr        = out_q.instr;
  assign b.ow_opc          = out_q.opc;
  assign b.ow_tgt_gp       = out_q.tgt_gp;
  assign b.ow_tgt_gp_we    = out_q.tgt_gp_we;
  assign b.ow_tgt_sr       = out_q.tgt_sr;
  assign b.ow_tgt_sr_we    = out_q.tgt_sr_we;
  assign b.ow_tgt_ar       = out_q.tgt_ar;
  assign b.ow_tgt_ar_we    = out_q.tgt_ar_we;
  assign b.ow_result       = out_q.result;
  assign b.ow_sr_result    = out_q.sr_result;
  assign b.ow_ar_result    = out_q.ar_result;
  assign b.ow_addr         = out_q.addr;
  assign b.ow_branch_pc    = out_q.branch_pc;
  assign b.ow_branch_taken = out_q.branch_taken;

  // Decode hints and AR/SR operands not consumed by this ALU subset
  assign unused_c = ^{b.iw_sgn_en, b.iw_imm_en, b.iw_imm14_val, b.iw_imm10_val,
                      b.iw_imm16_val, b.iw_src_gp, b.iw_src_ar, b.iw_src_ar_val,
                      b.iw_tgt_ar_val, b.iw_tgt_sr_val, b.iw_src_sr_val[ADDR_W-1:FLAG_W]};

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vectors plus randomized traffic
// compared against an arithmetic reference model of the execute stage.
`timescale 1ns/1ps
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ex_stage_if bus();

  ex_stage dut (.iw_clk(clk), .iw_rst(rst_n), .b(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  localparam longint unsigned M24 = 64'd1 << 24;

  typedef struct packed {
    logic [47:0] pc;
    logic [23:0] instr;
    logic [7:0]  opc;
    logic [3:0]  tgt_gp;
    logic        gp_we;
    logic [1:0]  tgt_sr;
    logic        sr_we;
    logic [1:0]  tgt_ar;
    logic [23:0] result;
    logic [47:0] sr_result;
  } exp_t;

  exp_t        ex;
  logic [11:0] m_bank [4];

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},        bus.ow_pc,        ex.pc);
    chk({tag, ".instr"},     bus.ow_instr,     48'(ex.instr));
    chk({tag, ".opc"},       bus.ow_opc,       48'(ex.opc));
    chk({tag, ".tgt_gp"},    bus.ow_tgt_gp,    48'(ex.tgt_gp));
    chk({tag, ".gp_we"},     bus.ow_tgt_gp_we, 48'(ex.gp_we));
    chk({tag, ".tgt_sr"},    bus.ow_tgt_sr,    48'(ex.tgt_sr));
    chk({tag, ".sr_we"},     bus.ow_tgt_sr_we, 48'(ex.sr_we));
    chk({tag, ".tgt_ar"},    bus.ow_tgt_ar,    48'(ex.tgt_ar));
    chk({tag, ".result"},    bus.ow_result,    48'(ex.result));
    chk({tag, ".sr_result"}, bus.ow_sr_result, ex.sr_result);
    chk({tag, ".ar_we"},     bus.ow_tgt_ar_we, 48'd0);
    chk({tag, ".ar_result"}, bus.ow_ar_result, 48'd0);
    chk({tag, ".addr"},      bus.ow_addr,      48'd0);
    chk({tag, ".br_pc"},     bus.ow_branch_pc, 48'd0);
    chk({tag, ".br_taken"},  bus.ow_branch_taken, 48'd0);
  endtask

  function automatic logic cond_ok(input int cc, input longint unsigned fl);
    logic z, c, n;
    z = fl[0]; n = fl[1]; c = fl[2];
    case (cc)
      0: return 1'b1;
      1: return z;
      2: return !z;
      3: return c;
      4: return !c;
      5: return n;
      6: return !n;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: what the stage must present after the next rising edge
  task automatic predict();
    longint unsigned t, s, imm, opnd, r, fl, p2;
    int amt, k, kind;   // kind: 0 unknown, 1 pass-through write, 2 flag+GP, 3 flag only
    logic c, ui;
    logic [7:0] op;
    if (bus.iw_stall) return;
    if (bus.iw_flush) begin ex = '0; return; end
    op   = bus.iw_opc;
    t    = 64'(bus.iw_tgt_gp_val);
    s    = 64'(bus.iw_src_gp_val);
    imm  = 64'(bus.iw_imm12_val);
    ui   = op inside {OPC_MOVUI, OPC_ADDUI, OPC_SUBUI, OPC_ANDUI, OPC_ORUI, OPC_XORUI,
                      OPC_SHLUI, OPC_SHRUI, OPC_ROLUI, OPC_RORUI, OPC_CMPUI, OPC_LUIUI};
    opnd = ui ? 64'(m_bank[0]) * 4096 + imm : s;
    amt  = int'(ui ? imm % 32 : s % 32);
    k    = amt % 24;
    r = 0; c = 1'b0; kind = 0;
    case (op)
      OPC_MOVUR, OPC_MOVUI: begin r = opnd; kind = 1; end
      OPC_ADDUR, OPC_ADDUI: begin r = (t + opnd) % M24; c = (t + opnd) >= M24; kind = 2; end
      OPC_SUBUR, OPC_SUBUI: begin r = (t + M24 - opnd) % M24; c = t < opnd; kind = 2; end
      OPC_CMPUR, OPC_CMPUI: begin r = (t + M24 - opnd) % M24; c = t < opnd; kind = 3; end
      OPC_ANDUR, OPC_ANDUI: begin r = t & opnd; kind = 2; end
      OPC_ORUR,  OPC_ORUI:  begin r = t | opnd; kind = 2; end
      OPC_XORUR, OPC_XORUI: begin r = t ^ opnd; kind = 2; end
      OPC_NOTUR:            begin r = M24 - 1 - t; kind = 2; end
      OPC_TSTUR:            begin r = t; kind = 3; end
      OPC_SHLUR, OPC_SHLUI: begin r = (amt >= 24) ? 0 : (t * (64'd1 << amt)) % M24; kind = 2; end
      OPC_SHRUR, OPC_SHRUI: begin r = (amt >= 24) ? 0 : t / (64'd1 << amt); kind = 2; end
`ifdef EX_ROTATE_EN
      OPC_ROLUR, OPC_ROLUI: begin
        p2 = t * (64'd1 << k);
        r = p2 % M24 + p2 / M24; kind = 2;
      end
      OPC_RORUR, OPC_RORUI: begin
        p2 = 64'd1 << k;
        r = t / p2 + (t % p2) * (64'd1 << (24 - k)); kind = 2;
      end
`endif
      OPC_MCCUR: begin
        fl = (bus.iw_src_sr == 2'b10) ? 64'(bus.iw_src_sr_val) % 16 : 0;
        r = cond_ok(int'(bus.iw_cc), fl) ? s : t; kind = 1;
      end
      OPC_LUIUI: begin
        m_bank[bus.iw_instr[15:14]] = bus.iw_imm12_val;
        r = 0; kind = 4;
      end
      default: begin r = 0; kind = 0; end
    endcase
    fl = (c ? 4 : 0) + (r >= (M24 / 2) ? 2 : 0) + (r == 0 ? 1 : 0);
    ex.pc        = bus.iw_pc;
    ex.instr     = bus.iw_instr;
    ex.opc       = op;
    ex.tgt_gp    = bus.iw_tgt_gp;
    ex.tgt_ar    = bus.iw_tgt_ar;
    ex.result    = 24'(r);
    ex.gp_we     = (kind == 1 || kind == 2) ? bus.iw_tgt_gp_we : 1'b0;
    ex.tgt_sr    = (kind == 2 || kind == 3) ? 2'b10 : bus.iw_tgt_sr;
    ex.sr_we     = (kind == 2 || kind == 3) ? 1'b1 :
                   (kind == 1 || kind == 4) ? bus.iw_tgt_sr_we : 1'b0;
    ex.sr_result = (kind == 2 || kind == 3) ? 48'(fl) : 48'd0;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [23:0] t, input logic [23:0] s,
                        input logic [11:0] imm);
    bus.iw_opc = op; bus.iw_tgt_gp_val = t; bus.iw_src_gp_val = s; bus.iw_imm12_val = imm;
  endtask

  task automatic tick(input string tag);
    predict();
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    ex = '0;
    for (int i = 0; i < 4; i++) m_bank[i] = 12'h0;
  endtask

  logic [7:0] op_tbl [27];

  initial begin
    op_tbl = '{OPC_NOP, OPC_MOVUR, OPC_MOVUI, OPC_ADDUR, OPC_ADDUI, OPC_SUBUR, OPC_SUBUI,
               OPC_ANDUR, OPC_ANDUI, OPC_ORUR, OPC_ORUI, OPC_XORUR, OPC_XORUI, OPC_NOTUR,
               OPC_SHLUR, OPC_SHLUI, OPC_SHRUR, OPC_SHRUI, OPC_ROLUR, OPC_ROLUI, OPC_RORUR,
               OPC_RORUI, OPC_CMPUR, OPC_CMPUI, OPC_TSTUR, OPC_MCCUR, OPC_LUIUI};
    bus.iw_pc = 48'h0000_0000_1000; bus.iw_instr = '0; bus.iw_opc = '0;
    bus.iw_sgn_en = 0; bus.iw_imm_en = 0; bus.iw_imm14_val = '0; bus.iw_imm12_val = '0;
    bus.iw_imm10_val = '0; bus.iw_imm16_val = '0; bus.iw_cc = '0;
    bus.iw_tgt_gp = 4'd3; bus.iw_tgt_gp_we = 1; bus.iw_tgt_sr = 2'd1; bus.iw_tgt_sr_we = 0;
    bus.iw_tgt_ar = 2'd1; bus.iw_src_gp = 4'd2; bus.iw_src_ar = '0; bus.iw_src_sr = '0;
    bus.iw_src_gp_val = '0; bus.iw_tgt_gp_val = '0; bus.iw_src_ar_val = '0;
    bus.iw_tgt_ar_val = '0; bus.iw_src_sr_val = '0; bus.iw_tgt_sr_val = '0;
    bus.iw_flush = 0; bus.iw_stall = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst_n = 1'b1;

    // Directed vectors
    set_op(OPC_MOVUR, 24'hDEADBE, 24'h123456, 12'h0); tick("movur");
    chk("movur_lit", bus.ow_result, 48'h123456);
    bus.iw_cc = CC_EQ; bus.iw_src_sr = 2'b10; bus.iw_src_sr_val = 48'h1;
    set_op(OPC_MCCUR, 24'hBBBBBB, 24'hAAAAAA, 12'h0); tick("mcc_t");
    chk("mcc_t_lit", bus.ow_result, 48'hAAAAAA);
    bus.iw_src_sr_val = 48'h0; tick("mcc_f");
    chk("mcc_f_lit", bus.ow_result, 48'hBBBBBB);
    set_op(OPC_ADDUR, 24'hFFFFFF, 24'h000001, 12'h0); tick("add_wrap");
    chk("add_lit", bus.ow_sr_result, 48'h5);
    set_op(OPC_SUBUR, 24'h000000, 24'h000001, 12'h0); tick("sub_borrow");
    chk("sub_lit", bus.ow_result, 48'hFFFFFF);
    set_op(OPC_ANDUR, 24'h33CC33, 24'h0F0F0F, 12'h0); tick("and");
    chk("and_lit", bus.ow_result, 48'h030C03);
    set_op(OPC_ORUR,  24'h33CC33, 24'h0F0F0F, 12'h0); tick("or");
    chk("or_lit", bus.ow_result, 48'h3FCF3F);
    set_op(OPC_XORUR, 24'h33CC33, 24'h0F0F0F, 12'h0); tick("xor");
    set_op(OPC_NOTUR, 24'h00FF00, 24'h0, 12'h0); tick("not");
    chk("not_lit", bus.ow_result, 48'hFF00FF);
    set_op(OPC_SHLUR, 24'h800001, 24'd1, 12'h0); tick("shl");
    chk("shl_lit", bus.ow_result, 48'h000002);
    set_op(OPC_SHRUR, 24'h800001, 24'd1, 12'h0); tick("shr");
    set_op(OPC_SHLUR, 24'hFFFFFF, 24'd24, 12'h0); tick("shl24");
    set_op(OPC_SHRUI, 24'hFFFFFF, 24'd0, 12'h01F); tick("shrui31");
    set_op(OPC_ROLUR, 24'h800000, 24'd1, 12'h0); tick("rol");
    set_op(OPC_RORUR, 24'h000001, 24'd1, 12'h0); tick("ror");
    set_op(OPC_RORUI, 24'h123456, 24'd0, 12'd28); tick("rorui28");
    bus.iw_instr = 24'h000000; set_op(OPC_LUIUI, 24'h0, 24'h0, 12'hABC); tick("lui0");
    bus.iw_instr = 24'h008000; set_op(OPC_LUIUI, 24'h0, 24'h0, 12'h555); tick("lui2");
    set_op(OPC_MOVUI, 24'h0, 24'h0, 12'hDEF); tick("movui");
    chk("movui_lit", bus.ow_result, 48'hABCDEF);
    bus.iw_instr = 24'h000000; set_op(OPC_LUIUI, 24'h0, 24'h0, 12'h000); tick("lui_clr");
    set_op(OPC_ADDUI, 24'h000010, 24'h0, 12'h001); tick("addui");
    chk("addui_lit", bus.ow_result, 48'h000011);
    set_op(OPC_SUBUI, 24'h000010, 24'h0, 12'h002); tick("subui");
    chk("subui_lit", bus.ow_result, 48'h00000E);
    set_op(OPC_CMPUR, 24'h4242AA, 24'h4242AA, 12'h0); tick("cmp_eq");
    chk("cmp_gpwe_lit", bus.ow_tgt_gp_we, 48'h0);
    set_op(OPC_TSTUR, 24'h800000, 24'h0, 12'h0); tick("tst");
    set_op(8'hEE, 24'h123456, 24'h654321, 12'h0); tick("unknown");

    // Stall holds, flush bubbles
    set_op(OPC_ADDUR, 24'h000100, 24'h000023, 12'h0); tick("pre_stall");
    bus.iw_stall = 1; set_op(OPC_XORUR, 24'hFFFFFF, 24'h0F0F0F, 12'h0); tick("stall");
    chk("stall_lit", bus.ow_result, 48'h000123);
    bus.iw_stall = 0; bus.iw_flush = 1; tick("flush");
    bus.iw_flush = 0;

    // Reset in the middle of a cycle
    set_op(OPC_ADDUR, 24'h000100, 24'h000001, 12'h0); tick("pre_rst");
    #2 rst_n = 1'b0;
    #1 model_reset(); check_all("rst_mid");
    @(negedge clk) rst_n = 1'b1;
    set_op(OPC_MOVUI, 24'h0, 24'h0, 12'h123); tick("bank_after_rst");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bus.iw_stall = ($urandom_range(0, 9) == 0);
      bus.iw_flush = ($urandom_range(0, 9) == 0);
      bus.iw_opc = ($urandom_range(0, 15) == 0) ? 8'($urandom) : op_tbl[$urandom_range(0, 26)];
      bus.iw_tgt_gp_val = 24'($urandom);
      bus.iw_src_gp_val = ($urandom_range(0, 1) == 0) ? 24'($urandom_range(0, 31)) : 24'($urandom);
      bus.iw_imm12_val = 12'($urandom);
      bus.iw_instr = 24'($urandom);
      bus.iw_pc = {16'($urandom), 32'($urandom)};
      bus.iw_cc = 4'($urandom_range(0, 8));
      bus.iw_src_sr = 2'($urandom);
      bus.iw_src_sr_val = {16'($urandom), 32'($urandom)};
      bus.iw_tgt_gp = 4'($urandom); bus.iw_tgt_gp_we = 1'($urandom);
      bus.iw_tgt_sr = 2'($urandom); bus.iw_tgt_sr_we = 1'($urandom);
      bus.iw_tgt_ar = 2'($urandom);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
